// File: rtl/fifo_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_collector                                                |
// | Purpose  : Polls BLOCKS serial FIFO lanes round-robin, fetches one word  |
// |            at a time over a 1-bit LSB-first link and presents it on a    |
// |            valid/ready output together with its lane index.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_collector #(
  parameter int BLOCKS    = 192,
  parameter int WORD_BITS = 64,
  parameter int ID_WIDTH  = 8     // 2**ID_WIDTH must cover BLOCKS
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 enable,
  input  logic [BLOCKS-1:0]    fifo_empty,
  input  logic [BLOCKS-1:0]    fifo_oflow,
  output logic [BLOCKS-1:0]    fifo_req,
  input  logic [BLOCKS-1:0]    fifo_bits,
  output logic [WORD_BITS-1:0] out_data,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 oflow_flag,
  input  logic                 oflow_clear,
  output logic [31:0]          word_count
);

  localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(WORD_BITS - 1);
  localparam logic [ID_WIDTH-1:0] LAST_LANE = ID_WIDTH'(BLOCKS - 1);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    REQ   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] ptr;
  logic [CNT_W-1:0]    bit_cnt;
  logic                started;   // holds off the first request for one edge after reset release
  logic [ID_WIDTH-1:0] ptr_next;

  // Round-robin successor of the current lane, wrapping at the last lane
  always_comb begin
    ptr_next = (ptr == LAST_LANE) ? '0 : ptr + 1'b1;
  end

  // Lane poller / word assembler FSM with all outputs registered
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= SCAN;
      ptr        <= '0;
      bit_cnt    <= '0;
      started    <= 1'b0;
      fifo_req   <= '0;
      out_data   <= '0;
      out_id     <= '0;
      out_valid  <= 1'b0;
      oflow_flag <= 1'b0;
      word_count <= '0;
    end else begin
      started  <= 1'b1;
      // A set in the same cycle as a clear wins, so no overflow is ever lost
      oflow_flag <= (|fifo_oflow) | (oflow_flag & ~oflow_clear);
      // Request is a single-cycle pulse; only the SCAN->REQ transition raises it
      fifo_req <= '0;

      case (state)
        SCAN: begin
          if (started) begin
            if (enable && !fifo_empty[ptr]) begin
              fifo_req[ptr] <= 1'b1;
              out_id        <= ptr;
              state         <= REQ;
            end else begin
              ptr <= ptr_next;
            end
          end
        end

        REQ: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end

        SHIFT: begin
          // LSB arrives first, so shifting right leaves bit 0 at the bottom
          out_data <= {fifo_bits[ptr], out_data[WORD_BITS-1:1]};
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            word_count <= word_count + 32'd1;
            ptr        <= ptr_next;
            state      <= SCAN;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
`default_nettype wire
